// File: rtl/raid_pkg.sv
// raid_pkg: shared types and constants for the RAID SD read path
package raid_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;
  typedef logic [1:0] disk_id_t;
  localparam disk_id_t DISK_NONE = 2'd3;
  localparam int WORD_W = 32;
  function automatic disk_id_t nxt(disk_id_t d);
    return d == 2'd2 ? 2'd0 : d + 2'd1;
  endfunction
endpackage

// File: rtl/sd_lane_hold.sv
// sd_lane_hold: one-word capture register with held flag and ready generation
module sd_lane_hold
  import raid_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic              blk,
  input  logic              clr,
  input  logic              valid,
  input  logic [WORD_W-1:0] data,
  output logic              ready,
  output logic              held,
  output logic [WORD_W-1:0] q
);
  assign ready = en & ~held & ~blk;
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      held <= 1'b0;
      q <= '0;
    end else if (clr) begin
      held <= 1'b0;
    end else if (valid & ready) begin
      held <= 1'b1;
      q <= data;
    end
  end
endmodule

// File: rtl/sd_data_out_rebuild.sv
// sd_data_out_rebuild: gathers one word per SD lane, routes/rebuilds the SRAM1/SRAM2 pair
module sd_data_out_rebuild
  import raid_pkg::*;
#(
  parameter int WORDS = 128,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [1:0]        sram1sd,
  input  logic [1:0]        sram2sd,
  input  logic              fail_en,
  input  logic [1:0]        fail_id,
  input  logic [WORD_W-1:0] sd_data0,
  input  logic [WORD_W-1:0] sd_data1,
  input  logic [WORD_W-1:0] sd_data2,
  input  logic [2:0]        sd_valid,
  output logic [2:0]        sd_ready,
  output logic [WORD_W-1:0] sram1_data,
  output logic [WORD_W-1:0] sram2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              cfg_err,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  disk_id_t s1_q, s2_q, fid_q, par;
  logic fen_q;
  logic [CNT_W-1:0] cnt;
  logic [WORD_W-1:0] lane [3];
  logic [WORD_W-1:0] data_in [3];
  logic [WORD_W-1:0] w1, w2;
  logic [2:0] held, blk;
  logic coll, accept, last, all_held, start_bad, start_ok, perr_now;
  assign data_in[0] = sd_data0;
  assign data_in[1] = sd_data1;
  assign data_in[2] = sd_data2;
  assign coll = state == COLLECT;
  assign accept = state == OUTPUT & out_ready;
  assign last = cnt == CNT_W'(WORDS - 1);
  assign blk = fen_q ? 3'(3'b001 << fid_q) : 3'b000;
  assign all_held = &(held | blk);
  assign start_bad = sram1sd == sram2sd | sram1sd == DISK_NONE | sram2sd == DISK_NONE
                   | fail_en & fail_id == DISK_NONE;
  assign start_ok = state == IDLE & start & ~start_bad;
  assign busy = state != IDLE;
  for (genvar g = 0; g < 3; g++) begin : g_lane
    sd_lane_hold u_hold (
      .clk(clk), .n_rst(n_rst), .en(coll), .blk(blk[g]), .clr(accept),
      .valid(sd_valid[g]), .data(data_in[g]),
      .ready(sd_ready[g]), .held(held[g]), .q(lane[g])
    );
  end
  // a lost data disk is rebuilt from the two lanes that survive it
  assign par = 2'd3 - s1_q - s2_q;
  assign w1 = fen_q && fid_q == s1_q ? lane[nxt(s1_q)] ^ lane[nxt(nxt(s1_q))] : lane[s1_q];
  assign w2 = fen_q && fid_q == s2_q ? lane[nxt(s2_q)] ^ lane[nxt(nxt(s2_q))] : lane[s2_q];
  assign perr_now = ~fen_q & ((lane[s1_q] ^ lane[s2_q]) != lane[par]);
  always_comb begin
    state_n = state == IDLE    ? (start_ok ? COLLECT : IDLE)
            : state == COLLECT ? (all_held ? OUTPUT : COLLECT)
            : accept ? (last ? IDLE : COLLECT) : OUTPUT;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      fid_q <= '0;
      fen_q <= 1'b0;
      cnt <= '0;
      sram1_data <= '0;
      sram2_data <= '0;
      out_valid <= 1'b0;
      parity_err <= 1'b0;
      cfg_err <= 1'b0;
      done <= 1'b0;
    end else begin
      cfg_err <= state == IDLE & start & start_bad;
      done <= accept & last;
      if (start_ok) begin
        s1_q <= sram1sd;
        s2_q <= sram2sd;
        fen_q <= fail_en;
        fid_q <= fail_en ? fail_id : 2'd0;
        parity_err <= 1'b0;
      end
      if (coll & all_held) begin
        sram1_data <= w1;
        sram2_data <= w2;
        out_valid <= 1'b1;
        if (perr_now) parity_err <= 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b0;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sd_data_out_rebuild.sv
// tb_sd_data_out_rebuild: directed and random stripes checked against a rule-level model
module tb_sd_data_out_rebuild;
  localparam int WORDS = 4;
  logic clk = 0, n_rst = 0, start = 0, fail_en = 0, out_ready = 0;
  logic [1:0] sram1sd = 0, sram2sd = 0, fail_id = 0;
  logic [31:0] sd_data0 = 0, sd_data1 = 0, sd_data2 = 0, sram1_data, sram2_data;
  logic [2:0] sd_valid = 0, sd_ready;
  logic out_valid, parity_err, cfg_err, busy, done;
  int checks = 0, failures = 0;
  logic [31:0] d [WORDS][3];
  int dly [3];

  sd_data_out_rebuild #(.WORDS(WORDS), .CNT_W(2)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .sram1sd(sram1sd), .sram2sd(sram2sd),
    .fail_en(fail_en), .fail_id(fail_id), .sd_data0(sd_data0), .sd_data1(sd_data1),
    .sd_data2(sd_data2), .sd_valid(sd_valid), .sd_ready(sd_ready),
    .sram1_data(sram1_data), .sram2_data(sram2_data), .out_valid(out_valid),
    .out_ready(out_ready), .parity_err(parity_err), .cfg_err(cfg_err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(logic [31:0] l [3], int id, int fen, int fid);
    logic [31:0] x = 0;
    if (fen == 0 || fid != id) return l[id];
    for (int j = 0; j < 3; j++) if (j != id) x ^= l[j];
    return x;
  endfunction

  task automatic run_stripe(input int s1, input int s2, input int fen, input int fid,
                            input int hold, input bit mid_start, input bit abort);
    logic [31:0] l [3];
    logic [31:0] e1, e2;
    logic [2:0] got, fire;
    bit perr;
    int par, cyc;
    sram1sd = 2'(s1); sram2sd = 2'(s2); fail_en = fen[0]; fail_id = 2'(fid);
    start = 1;
    tick;
    start = 0;
    chk("busy_start", 32'(busy), 32'd1);
    chk("perr_clr", 32'(parity_err), 32'd0);
    perr = 0;
    par = 3 - s1 - s2;
    for (int w = 0; w < WORDS; w++) begin
      for (int i = 0; i < 3; i++) l[i] = d[w][i];
      e1 = model_word(l, s1, fen, fid);
      e2 = model_word(l, s2, fen, fid);
      if (fen == 0 && (l[s1] ^ l[s2]) != l[par]) perr = 1;
      sd_data0 = l[0]; sd_data1 = l[1]; sd_data2 = l[2];
      got = fen != 0 ? 3'(1 << fid) : 3'd0;
      cyc = 0;
      while (got != 3'b111 && cyc < 50) begin
        for (int i = 0; i < 3; i++)
          sd_valid[i] = !got[i] && (dly[i] < 0 ? $urandom_range(0, 1) == 1 : cyc >= dly[i]);
        if (fen != 0) sd_valid[fid] = 1'b1;
        if (mid_start && w == 0 && cyc == 0) begin
          start = 1; sram1sd = 2'(par); sram2sd = 2'(s1);
        end
        if (fen != 0) chk("fail_rdy", 32'(sd_ready[fid]), 32'd0);
        fire = sd_valid & sd_ready;
        tick;
        if (start) chk("mid_cfg_err", 32'(cfg_err), 32'd0);
        start = 0; sram1sd = 2'(s1); sram2sd = 2'(s2);
        got |= fire;
        cyc++;
      end
      sd_valid = 0;
      if (got != 3'b111) begin
        chk("collect_timeout", 32'(got), 32'd7);
        return;
      end
      chk("ov_lat0", 32'(out_valid), 32'd0);
      tick;
      chk("ov_lat1", 32'(out_valid), 32'd1);
      chk("sram1", sram1_data, e1);
      chk("sram2", sram2_data, e2);
      chk("perr", 32'(parity_err), 32'(perr));
      if (abort) begin
        n_rst = 0;
        tick;
        n_rst = 1;
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick;
        chk("abort_done2", 32'(done), 32'd0);
        return;
      end
      for (int k = 0; k < hold; k++) begin
        tick;
        chk("hold_ov", 32'(out_valid), 32'd1);
        chk("hold_s1", sram1_data, e1);
        chk("hold_s2", sram2_data, e2);
        chk("hold_rdy", 32'(sd_ready), 32'd0);
      end
      out_ready = 1;
      tick;
      out_ready = 0;
      chk("acc_ov", 32'(out_valid), 32'd0);
      chk("acc_done", 32'(done), 32'(w == WORDS - 1));
      chk("acc_busy", 32'(busy), 32'(w != WORDS - 1));
    end
    chk("perr_sticky", 32'(parity_err), 32'(perr));
    tick;
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int w = 0; w < WORDS; w++) begin
      d[w][0] = a; d[w][1] = b; d[w][2] = c;
    end
  endtask

  initial begin
    int s1, s2, fen, fid, par;
    int bad [4][4] = '{'{2, 2, 0, 0}, '{3, 0, 0, 0}, '{0, 3, 0, 0}, '{0, 1, 1, 3}};
    repeat (3) tick;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(sd_ready), 32'd0);
    chk("rst_s1", sram1_data, 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    n_rst = 1;
    tick;
    chk("idle_rdy", 32'(sd_ready), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    dly = '{0, 0, 0};
    fill(32'hA5A5_0000, 32'h0F0F_FFFF, 32'hAAAA_FFFF);
    run_stripe(0, 1, 0, 0, 0, 0, 0);
    d[0][2] = 32'h0000_0001;
    run_stripe(0, 1, 0, 0, 1, 0, 0);
    fill(32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_0000);
    run_stripe(0, 1, 1, 1, 0, 0, 0);
    chk("fail_rebuild", sram2_data, 32'h0000_5678);
    fill(32'h1111_0000, 32'h2222_0000, 32'h3333_0000);
    dly = '{2, 4, 0};
    run_stripe(2, 0, 0, 0, 5, 1, 0);
    for (int b = 0; b < 4; b++) begin
      sram1sd = 2'(bad[b][0]); sram2sd = 2'(bad[b][1]);
      fail_en = bad[b][2][0]; fail_id = 2'(bad[b][3]);
      start = 1;
      tick;
      start = 0;
      chk("cfg_err", 32'(cfg_err), 32'd1);
      chk("cfg_busy", 32'(busy), 32'd0);
      tick;
      chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
    end
    dly = '{1, 0, 2};
    fill(32'hA5A5_0000, 32'h0F0F_FFFF, 32'hAAAA_FFFF);
    run_stripe(0, 1, 0, 0, 0, 0, 1);
    run_stripe(0, 1, 0, 0, 2, 0, 0);
    for (int r = 0; r < 12; r++) begin
      s1 = $urandom_range(0, 2);
      s2 = (s1 + 1 + $urandom_range(0, 1)) % 3;
      fen = $urandom_range(0, 1);
      fid = $urandom_range(0, 2);
      par = 3 - s1 - s2;
      for (int w = 0; w < WORDS; w++) begin
        for (int i = 0; i < 3; i++) d[w][i] = $urandom;
        if ($urandom_range(0, 1) == 1) d[w][par] = d[w][s1] ^ d[w][s2];
      end
      for (int i = 0; i < 3; i++) dly[i] = $urandom_range(0, 1) == 1 ? -1 : $urandom_range(0, 3);
      run_stripe(s1, s2, fen, fid, $urandom_range(0, 3), 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_data_out_rebuild.md
Name: sd_data_out_rebuild

Overview:
- Read-path counterpart of the SD data-in selector. During a stripe read it collects one 32-bit word from each of the three SD card lanes.
- Each word is routed back to its SRAM destination (SRAM1 or SRAM2) using the per-stripe disk mapping.
- If one disk is marked failed, its word is rebuilt by XOR of the surviving two. If no disk is failed, data is checked against parity.
- Sits between the three SD read engines and the SRAM write controller.

Parameters:
- WORDS, 128, words per stripe block per disk (512-byte sector / 4).
- CNT_W, 7, width of word counter (clog2(WORDS)).

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a stripe read, latches config
- sram1sd  in  2  disk id (0..2) holding SRAM1 data
- sram2sd  in  2  disk id (0..2) holding SRAM2 data
- fail_en  in  1  one disk is failed/absent
- fail_id  in  2  id of failed disk, valid when fail_en
- sd_data0, sd_data1, sd_data2  in  32 each  read data from SD lanes 0/1/2
- sd_valid  in  3  per-lane word valid
- sd_ready  out  3  per-lane word accept
- sram1_data  out  32  word for SRAM1
- sram2_data  out  32  word for SRAM2
- out_valid  out  1  sram1_data/sram2_data valid
- out_ready  in  1  SRAM side accepts the pair
- parity_err  out  1  sticky mismatch flag for the current stripe
- cfg_err  out  1  one-cycle pulse on illegal config at start
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after last pair is accepted

Behaviour:
- Reset: all outputs 0, state IDLE, word count 0, lane-held flags 0, latched config 0.
- Parity disk id = 3 - sram1sd - sram2sd, computed from latched values.
- IDLE, start=1: config is illegal if any of these hold → cfg_err pulses next cycle, stay IDLE:
  - sram1sd==sram2sd;
  - either id ==3;
  - fail_en and fail_id==3.
- IDLE, start=1, legal config: latch config, clear parity_err, go COLLECT.
- start outside IDLE is ignored.
- COLLECT:
  - sd_ready[i] = ~held[i] & ~(fail_en & fail_id==i).
  - On sd_valid[i]&sd_ready[i]: capture sd_data_i into lane reg i, set held[i].
  - Failed lane: sd_ready is 0; its data and valid are ignored.
  - Lanes may complete in any order, including the same cycle.
- COLLECT → OUTPUT on the first cycle all non-failed lanes are held (registered check, so the cycle after the last capture edge). On that edge, load sram1_data/sram2_data:
  - source lane = mapped disk;
  - if mapped disk == failed disk, the word is the XOR of the other two lanes;
  - failed parity disk → direct route, no rebuild;
  - no failure: if lane[s1]^lane[s2] != lane[par], set parity_err (stays set until next legal start).
- OUTPUT: out_valid=1; data held stable until out_ready.
- OUTPUT, out_valid&out_ready:
  - clear held flags, out_valid=0, increment count;
  - if count==WORDS-1: done pulse, count←0, IDLE;
  - else back to COLLECT.
- Latency: last lane capture at edge N → out_valid high after edge N+1. One word pair per ≥2 cycles.
- n_rst low at any cycle: immediate return to reset state next edge; partial stripe discarded, no done.

Decomposition:
- Package raid_pkg:
  - state enum {IDLE, COLLECT, OUTPUT};
  - typedef disk_id_t logic[1:0];
  - constants DISK_NONE=2'd3, WORD_W=32.
- Sub-module sd_lane_hold (one 32-bit capture register + held flag + ready gen), instantiated 3×. XOR/route logic stays in top.

Test Plan:
- Healthy stripe, WORDS=2, sram1sd=0, sram2sd=1 (parity 2), lanes give A5A5_0000/0F0F_FFFF/AAAA_FFFF, out_ready=1 → sram1=A5A5_0000, sram2=0F0F_FFFF, parity_err=0, done after 2nd pair.
- Same stripe, lane 2 word = 0000_0001 → parity_err=1 and sticky through done; cleared by next start.
- fail_en=1, fail_id=1, lanes 0=1234_5678, 2=1234_0000 → sd_ready[1]=0, sram2_data=0000_5678.
- Lanes arrive out of order (2, then 0, then 1 two cycles apart); hold out_ready=0 for 5 cycles → data stable, sd_ready all 0 until accepted.
- start with sram1sd=sram2sd=2 → cfg_err pulse, busy stays 0; start mid-COLLECT ignored.
- n_rst asserted in OUTPUT mid-stripe → out_valid=0, busy=0 next cycle, no done; fresh stripe then completes normally.
